// File: rtl/axis_decim_out.sv
// Keeps one sample in every decim, applies a shift gain with signed saturation and buffers results in a FIFO.
// Latency is 2 cycles. s_axis_tready drops when stage+FIFO are full, and samples offered then are dropped and flagged.

module axis_decim_out_fifo #(
   parameter  int W     = 16,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_vld_i,
   input  logic [W-1:0]  push_dat_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_dat_o,
   output logic [CW-1:0] count_o
);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_vld_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(push_vld_i) - CW'(pop_i);
      end
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;
endmodule

module axis_decim_out #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [CNT_WIDTH-1:0]  decim,
   input  logic [CNT_WIDTH-1:0]  phase,
   input  logic [3:0]            gain_shift,
   input  logic                  clr_flags,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  overflow,
   output logic                  saturated
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int XW = DATA_WIDTH + 15;
   localparam logic signed [XW-1:0] SAT_MAX = XW'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [XW-1:0] SAT_MIN = XW'(-(2 ** (DATA_WIDTH - 1)));

   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, decim_eff;
   logic                  stage_vld_q, stage_vld_d;
   logic [DATA_WIDTH-1:0] stage_dat_q, stage_dat_d;
   logic                  overflow_q, overflow_d;
   logic                  saturated_q, saturated_d;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_push, fifo_pop, keep, drop, clip_hi, clip_lo;
   logic signed [XW-1:0]  stage_ext, gained;
   logic [DATA_WIDTH-1:0] sat_dat;

   assign decim_eff     = (decim == '0) ? CNT_WIDTH'(1) : decim;
   // Occupancy counts the stage register so a kept sample always has a FIFO slot to move into.
   assign s_axis_tready = (fifo_count + CW'(stage_vld_q)) < CW'(FIFO_DEPTH);
   assign keep          = s_axis_tvalid && s_axis_tready && (cnt_q == phase);
   assign drop          = s_axis_tvalid && !s_axis_tready;
   assign m_axis_tvalid = (fifo_count != '0);
   assign fifo_pop      = m_axis_tvalid && m_axis_tready;
   assign fifo_push     = stage_vld_q && ((fifo_count < CW'(FIFO_DEPTH)) || fifo_pop);

   assign stage_ext = {{(XW - DATA_WIDTH){stage_dat_q[DATA_WIDTH-1]}}, stage_dat_q};
   assign gained    = stage_ext <<< gain_shift;
   assign clip_hi   = gained > SAT_MAX;
   assign clip_lo   = gained < SAT_MIN;
   assign sat_dat   = clip_hi ? {1'b0, {(DATA_WIDTH - 1){1'b1}}} :
                      clip_lo ? {1'b1, {(DATA_WIDTH - 1){1'b0}}} : gained[DATA_WIDTH-1:0];

   always_comb begin
      cnt_d       = cnt_q;
      stage_vld_d = stage_vld_q;
      stage_dat_d = stage_dat_q;
      // Every offered sample advances the phase, dropped or not, to stay locked to the input rate.
      if (s_axis_tvalid)
         cnt_d = (cnt_q >= decim_eff - CNT_WIDTH'(1)) ? '0 : cnt_q + CNT_WIDTH'(1);
      if (keep) begin
         stage_vld_d = 1'b1;
         stage_dat_d = s_axis_tdata;
      end else if (fifo_push) begin
         stage_vld_d = 1'b0;
      end
      overflow_d  = (overflow_q && !clr_flags) || drop;
      saturated_d = (saturated_q && !clr_flags) || (fifo_push && (clip_hi || clip_lo));
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q       <= '0;
         stage_vld_q <= 1'b0;
         stage_dat_q <= '0;
         overflow_q  <= 1'b0;
         saturated_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         stage_vld_q <= stage_vld_d;
         stage_dat_q <= stage_dat_d;
         overflow_q  <= overflow_d;
         saturated_q <= saturated_d;
      end
   end

   axis_decim_out_fifo #(
      .W     (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (aclk),
      .rst_ni     (aresetn),
      .push_vld_i (fifo_push),
      .push_dat_i (sat_dat),
      .pop_i      (fifo_pop),
      .head_dat_o (m_axis_tdata),
      .count_o    (fifo_count)
   );

   assign overflow  = overflow_q;
   assign saturated = saturated_q;
endmodule
